// File: rtl/pulse_gen_ms_pkg.sv
// Shared constants for the ms-domain blocks (pulse generator, press timer, display).
// State encodings are kept as plain 2-bit constants so older blocks can share them.
package pulse_gen_ms_pkg;

  localparam int MAX_MS_DEFAULT   = 9_999;
  localparam int TICK_DIV_DEFAULT = 50_000;
  localparam int CW_DEFAULT       = 15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/pulse_gen_ms_tick.sv
// 1 ms tick divider on clk: counts 0..TICK_DIV-1 while enabled, one-cycle tick at terminal count.
// Replaces a derived 1 kHz clock so all ms logic stays in the clk domain.
module ms_tick #(
  parameter int TICK_DIV = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             term;

  assign term = (cnt_reg == TERM);
  assign tick = en & term;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= term ? '0 : cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulse_gen_ms.sv
// Single-shot pulse generator: on a start edge drives pulso high for min(duracion, MAX_MS) ms.
// Exposes the elapsed ms count for the display path; done strobes on normal completion only.
module pulse_gen_ms
  import pulse_gen_ms_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int MAX_MS   = MAX_MS_DEFAULT,
  parameter int CW       = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          cancel,
  input  logic [CW-1:0] duracion,
  output logic          pulso,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] elapsed_ms
);

  localparam logic [CW-1:0] MAX_MS_C = CW'(MAX_MS);

  logic          start_q_reg;
  logic          start_edge;
  logic [1:0]    state_reg, state_next;
  logic          pulso_reg, pulso_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [CW-1:0] elapsed_reg, elapsed_next;
  logic [CW-1:0] len_reg, len_next;
  logic          tick;
  logic          tick_en;

  assign start_edge = start & ~start_q_reg;
  assign tick_en    = (state_reg == ST_RUN);

  // Divider is held at zero outside RUN, so every accepted pulse starts on a fresh ms.
  ms_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_ms_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (~tick_en),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    state_next   = state_reg;
    pulso_next   = pulso_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    elapsed_next = elapsed_reg;
    len_next     = len_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_edge && (duracion != '0)) begin
          len_next     = (duracion > MAX_MS_C) ? MAX_MS_C : duracion;
          elapsed_next = '0;
          state_next   = ST_RUN;
          pulso_next   = 1'b1;
          busy_next    = 1'b1;
        end
      end
      ST_RUN: begin
        // cancel beats a coincident final tick: partial count kept, no done
        if (cancel) begin
          state_next = ST_IDLE;
          pulso_next = 1'b0;
          busy_next  = 1'b0;
        end else if (tick) begin
          elapsed_next = elapsed_reg + CW'(1);
          if (elapsed_reg == len_reg - CW'(1)) begin
            state_next = ST_DONE;
            pulso_next = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        pulso_next = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q_reg <= 1'b0;
      state_reg   <= ST_IDLE;
      pulso_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      elapsed_reg <= '0;
      len_reg     <= '0;
    end else begin
      start_q_reg <= start;
      state_reg   <= state_next;
      pulso_reg   <= pulso_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      elapsed_reg <= elapsed_next;
      len_reg     <= len_next;
    end
  end

  assign pulso      = pulso_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign elapsed_ms = elapsed_reg;

endmodule

// File: tb/tb_pulse_gen_ms.sv
// Directed bench for pulse_gen_ms: one instance at TICK_DIV=10 for timing cases,
// one at TICK_DIV=1 for the MAX_MS clamp.
module tb_pulse_gen_ms;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, cancel;
  logic [14:0] duracion;
  logic        pulso, busy, done;
  logic [14:0] elapsed_ms;

  logic        start1, cancel1;
  logic [14:0] duracion1;
  logic        pulso1, busy1, done1;
  logic [14:0] elapsed_ms1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pulse_gen_ms #(.TICK_DIV(10), .MAX_MS(9999), .CW(15)) dut (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel), .duracion(duracion),
    .pulso(pulso), .busy(busy), .done(done), .elapsed_ms(elapsed_ms)
  );

  pulse_gen_ms #(.TICK_DIV(1), .MAX_MS(9999), .CW(15)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .cancel(cancel1), .duracion(duracion1),
    .pulso(pulso1), .busy(busy1), .done(done1), .elapsed_ms(elapsed_ms1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a negedge: presents a start edge, then samples every negedge for `budget` cycles.
  task automatic run_pulse(input string tag, input logic [14:0] d, input int budget,
                           input int cancel_at, input int retrig_at, input bit hold_start,
                           input int exp_hi, input int exp_dn, input int exp_el,
                           input int exp_first);
    int hi, dn, first, busy_bad;
    hi = 0; dn = 0; first = -1; busy_bad = 0;
    chk({tag, ".pre_pulso"}, int'(pulso), 0);
    duracion = d;
    start = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pulso) begin
        hi++;
        if (first < 0) first = i;
      end
      if (done) dn++;
      if (busy !== pulso) busy_bad++;
      if (i == 0 && !hold_start) start = 1'b0;
      if (i == retrig_at) begin start = 1'b1; duracion = 15'd9; end
      if (i == retrig_at + 2) start = 1'b0;
      cancel = (i == cancel_at);
    end
    cancel = 1'b0;
    chk({tag, ".high_cycles"}, hi, exp_hi);
    chk({tag, ".done_count"}, dn, exp_dn);
    chk({tag, ".elapsed"}, int'(elapsed_ms), exp_el);
    chk({tag, ".first_high"}, first, exp_first);
    chk({tag, ".busy_mirror"}, busy_bad, 0);
    $display("pulse %s: d=%0d high=%0d done=%0d elapsed=%0d", tag, d, hi, dn, elapsed_ms);
  endtask

  initial begin
    int hi1, dn1;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; duracion = '0;
    start1 = 1'b0; cancel1 = 1'b0; duracion1 = '0;
    repeat (3) @(negedge clk);
    chk("reset.pulso", int'(pulso), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.elapsed", int'(elapsed_ms), 0);
    reset = 1'b0;
    @(negedge clk);

    // 3 ms at 10 cycles/ms
    run_pulse("basic3", 15'd3, 45, -1, -1, 1'b0, 30, 1, 3, 0);
    chk("basic3.done_after", int'(done), 0);

    // zero duration ignored; elapsed keeps previous value
    run_pulse("zero", 15'd0, 50, -1, -1, 1'b0, 0, 0, 3, -1);

    // cancel seen at end of pulse cycle 23 (1-based)
    run_pulse("cancel5", 15'd5, 40, 22, -1, 1'b0, 23, 0, 2, 0);
    chk("cancel5.busy_after", int'(busy), 0);
    run_pulse("after_cancel", 15'd1, 20, -1, -1, 1'b0, 10, 1, 1, 0);

    // retrigger + duracion change mid-pulse has no effect
    run_pulse("retrig4", 15'd4, 60, -1, 10, 1'b0, 40, 1, 4, 0);

    // cancel on the final terminal tick of a 2 ms pulse
    run_pulse("cancel_last", 15'd2, 30, 19, -1, 1'b0, 20, 0, 1, 0);

    // reset mid-pulse, start held high across reset release
    duracion = 15'd5;
    start = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("midreset.pulso", int'(pulso), 0);
    chk("midreset.busy", int'(busy), 0);
    chk("midreset.done", int'(done), 0);
    chk("midreset.elapsed", int'(elapsed_ms), 0);
    reset = 1'b0;
    start = 1'b0;
    run_pulse("held_start", 15'd2, 60, -1, -1, 1'b1, 20, 1, 2, 0);
    start = 1'b0;
    @(negedge clk);

    // clamp at MAX_MS with TICK_DIV=1
    hi1 = 0; dn1 = 0;
    duracion1 = 15'd15000;
    start1 = 1'b1;
    for (int i = 0; i < 10100; i++) begin
      @(negedge clk);
      if (pulso1) hi1++;
      if (done1) dn1++;
      start1 = 1'b0;
    end
    chk("clamp.high_cycles", hi1, 9999);
    chk("clamp.done_count", dn1, 1);
    chk("clamp.elapsed", int'(elapsed_ms1), 9999);
    chk("clamp.busy", int'(busy1), 0);
    $display("pulse clamp: d=15000 high=%0d done=%0d elapsed=%0d", hi1, dn1, elapsed_ms1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
